sequence_generator: RTL
=======================

Name: sequence_generator

Overview:
- Serial pattern transmitter that drives the single-bit `w` stream consumed by the team's binary-encoded sequence-detector FSM.
- On a start request it latches a W-bit pattern and shifts it out MSB-first, one bit per clock.
- It repeats the pattern a programmable number of times, with an idle gap between repetitions.
- It then pulses `done`.
- Used as detector stimulus source and as the on-board pattern source driving the detector's `w` input.

Parameters:
- PATTERN_WIDTH, 4: bits per pattern (W); legal 2..16.
- GAP_CYCLES, 1: idle cycles (`w`=0, `w_valid`=0) between repetitions; legal 0..15.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request transmission; sampled only in IDLE.
- pattern  input  PATTERN_WIDTH  bits to send, MSB first; latched on accepted start.
- repeat_count  input  4  number of pattern repetitions; latched on accepted start.
- w  output  1  serial bit out.
- w_valid  output  1  high when `w` carries a pattern bit.
- busy  output  1  high in SHIFT and GAP.
- done  output  1  one-cycle pulse after the final bit.
- state_out  output  2  current state encoding, for debug/LEDs.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - State goes to IDLE immediately.
  - `w`, `w_valid`, `busy`, `done` go to 0; `state_out`=00.
  - Shift register, bit counter, repeat counter and gap counter clear to 0.
  - Applies at any point mid-operation; no partial frame resumes after release.
- State encoding:
  - IDLE=00, SHIFT=01, GAP=10, DONE=11.
  - All outputs are Moore outputs decoded from registered state and registers; no combinational path from inputs to outputs.
- IDLE:
  - `w`=0, `w_valid`=0, `busy`=0.
  - On a rising edge with `start`=1 and `repeat_count`!=0:
    - latch `pattern` into the shift register and into the pattern hold register;
    - load the repeat counter with `repeat_count` and the bit counter with W-1;
    - go to SHIFT.
  - `start`=1 with `repeat_count`=0: ignored; stay in IDLE; no `done`.
- SHIFT:
  - `w` = shift register MSB, `w_valid`=1, `busy`=1.
  - Each edge: shift left by one and decrement the bit counter.
  - When the bit counter is 0 at the edge, the last bit of the repetition is finished; decrement the repeat counter, then:
    - repeat counter was 1 → DONE.
    - otherwise, GAP_CYCLES>0 → GAP, gap counter = GAP_CYCLES-1.
    - otherwise (GAP_CYCLES=0) → stay in SHIFT; reload the shift register from the hold register and the bit counter with W-1, so bits are back-to-back with no bubble.
- GAP:
  - `w`=0, `w_valid`=0, `busy`=1.
  - Gap counter decrements each edge.
  - At 0: reload the shift register and bit counter, then go to SHIFT.
- DONE:
  - `done`=1 for exactly one cycle; `busy`=0, `w_valid`=0.
  - Unconditionally go to IDLE.
  - `start` is ignored in this cycle.
- Latency: `start` accepted at edge t0 → first bit on `w` in the cycle after t0.
- Cycle counts:
  - `busy` high for W*R + GAP_CYCLES*(R-1) cycles (R = latched `repeat_count`).
  - `done` is high in the following cycle.
- Input changes:
  - `start` while `busy`=1 is ignored.
  - Changes to `pattern` or `repeat_count` after acceptance have no effect on the frame in flight.
- Width rules:
  - Counters are sized for their maximum values (bit counter ceil(log2 W), gap counter 4 bits).
  - No wrap-around is reachable in legal operation.

Test Plan:
- W=4, GAP=1, `pattern`=4'b1011, `repeat_count`=1, `start` pulse → `w`=1,0,1,1 with `w_valid`=1 on 4 consecutive cycles starting the cycle after start; `done`=1 on cycle 5; `state_out` 01 then 11 then 00.
- Same pattern, `repeat_count`=2 → `w` = 1011, one GAP cycle (`w_valid`=0, `busy`=1), 1011; `busy` high 9 cycles; single `done` pulse.
- GAP_CYCLES=0, `pattern`=4'b1001, `repeat_count`=3 → contiguous 100110011001 over 12 cycles, `w_valid` never drops; then `done`.
- `start`=1 with `repeat_count`=0 → `state_out` stays 00; `busy`, `w_valid`, `done` stay 0.
- During a frame, re-pulse `start` with `pattern`=4'b0000 → ignored; the original bits continue unchanged; exactly one `done`.
- Drive `reset`=0 asynchronously after 2 bits → all outputs 0 and `state_out`=00 before the next edge. Release reset, then start `pattern`=4'b1110 → clean 1,1,1,0 followed by `done`.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched W-bit pattern out MSB-first, repeats it
// a programmable number of times with idle gaps, then pulses done.
module sequence_generator #(
    parameter int unsigned PATTERN_WIDTH = 4,
    parameter int unsigned GAP_CYCLES    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PATTERN_WIDTH-1:0] pattern,
    input  logic [3:0]               repeat_count,
    output logic                     w,
    output logic                     w_valid,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               state_out
);

    localparam int unsigned BitCntW = $clog2(PATTERN_WIDTH);
    localparam logic [BitCntW-1:0] BitLast = BitCntW'(PATTERN_WIDTH - 1);
    localparam logic [3:0] GapLoad = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StGap   = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e                   state_q, state_d;
    logic [PATTERN_WIDTH-1:0] shift_q, shift_d;
    logic [PATTERN_WIDTH-1:0] hold_q, hold_d;
    logic [BitCntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]               rep_q, rep_d;
    logic [3:0]               gap_q, gap_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            hold_q    <= '0;
            bit_cnt_q <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            bit_cnt_q <= bit_cnt_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        bit_cnt_d = bit_cnt_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        unique case (state_q)
            StIdle: begin
                if (start && repeat_count != 4'd0) begin
                    shift_d   = pattern;
                    hold_d    = pattern;
                    rep_d     = repeat_count;
                    bit_cnt_d = BitLast;
                    state_d   = StShift;
                end
            end
            StShift: begin
                shift_d   = {shift_q[PATTERN_WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 1'b1;
                if (bit_cnt_q == '0) begin
                    rep_d     = rep_q - 4'd1;
                    bit_cnt_d = '0;
                    if (rep_q == 4'd1) begin
                        state_d = StDone;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                        gap_d   = GapLoad;
                    end else begin
                        // No gap: reload immediately so repetitions run back-to-back.
                        shift_d   = hold_q;
                        bit_cnt_d = BitLast;
                    end
                end
            end
            StGap: begin
                gap_d = gap_q - 4'd1;
                if (gap_q == 4'd0) begin
                    gap_d     = '0;
                    shift_d   = hold_q;
                    bit_cnt_d = BitLast;
                    state_d   = StShift;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs: decoded only from registered state.
    always_comb begin
        w         = (state_q == StShift) && shift_q[PATTERN_WIDTH-1];
        w_valid   = (state_q == StShift);
        busy      = (state_q == StShift) || (state_q == StGap);
        done      = (state_q == StDone);
        state_out = state_q;
    end

endmodule
